usb_stream_buffer: RTL and testbench

USB_STREAM_BUFFER -- requirements
Module: usb_stream_buffer

---
 rtl/usb_stream_buffer.sv | 105 ++++++++++
 tb/tb_usb_stream_buffer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/usb_stream_buffer.sv
// usb_stream_buffer: sample FIFO that drains to an FX3 slave FIFO in fixed-size bursts
// Ports: clock, nReset (async, active-low); capture side runFlag, adcData;
//        FX3 side fx3Ready, usbData, usbWrite, usbEndOfBurst; status overflow, fillLevel.
// Build option: define TEST_PATTERN_EN to store a 16-bit word counter instead of adcData.
module usb_stream_buffer #(
    parameter int DEPTH = 1024,
    parameter int BURST = 256
) (
    input  logic                     clock,
    input  logic                     nReset,
    input  logic                     runFlag,
    input  logic [15:0]              adcData,
    input  logic                     fx3Ready,
    output logic [15:0]              usbData,
    output logic                     usbWrite,
    output logic                     usbEndOfBurst,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fillLevel
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(BURST) + 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] BURST_LVL = (AW + 1)'(BURST);
    localparam logic [BW-1:0] LAST = BW'(BURST - 1);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [BW-1:0] wordCnt, wordCntNext;
    logic [15:0]   wrData, usbDataNext;
    logic          runPrev, runRise, full, wrEn, rdEn;
    logic          usbWriteNext, usbEndNext;
    state_t        state, stateNext;

    // A fresh capture run restarts the buffer; that cycle only clears, it stores nothing.
    assign runRise = runFlag & ~runPrev;
    assign full = fillLevel == FULL;
    assign wrEn = runFlag & ~runRise & ~full;
    // Bursts only start with BURST words stored, so a read never finds the FIFO empty.
    assign rdEn = (state == S_BURST) & fx3Ready & ~runRise;

`ifdef TEST_PATTERN_EN
    logic [15:0] pattern;
    always_ff @(posedge clock or negedge nReset)
        if (!nReset)
            pattern <= '0;
        else if (runRise)
            pattern <= '0;
        else if (wrEn)
            pattern <= pattern + 16'd1;
    assign wrData = pattern;
`else
    assign wrData = adcData;
`endif

    always_ff @(posedge clock)
        if (wrEn)
            mem[wrPtr] <= wrData;

    always_ff @(posedge clock or negedge nReset)
        if (!nReset) begin
            runPrev   <= 1'b0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            fillLevel <= '0;
            overflow  <= 1'b0;
        end else begin
            runPrev   <= runFlag;
            wrPtr     <= runRise ? '0 : wrPtr + AW'(wrEn);
            rdPtr     <= runRise ? '0 : rdPtr + AW'(rdEn);
            fillLevel <= runRise ? '0 : fillLevel + (AW + 1)'(wrEn) - (AW + 1)'(rdEn);
            // A sample arriving while full is lost even if a read frees a slot this cycle.
            overflow  <= runRise ? 1'b0 : overflow | (runFlag & full);
        end

    always_ff @(posedge clock or negedge nReset)
        if (!nReset) begin
            state         <= S_IDLE;
            wordCnt       <= '0;
            usbData       <= '0;
            usbWrite      <= 1'b0;
            usbEndOfBurst <= 1'b0;
        end else begin
            state         <= stateNext;
            wordCnt       <= wordCntNext;
            usbData       <= usbDataNext;
            usbWrite      <= usbWriteNext;
            usbEndOfBurst <= usbEndNext;
        end

    always_comb begin
        stateNext = runRise ? S_IDLE :
                    state == S_IDLE  ? ((fillLevel >= BURST_LVL && fx3Ready) ? S_BURST : S_IDLE) :
                    state == S_BURST ? ((rdEn && wordCnt == LAST) ? S_GAP : S_BURST) :
                    S_IDLE;
    end

    always_comb begin
        wordCntNext  = state == S_IDLE ? '0 : wordCnt + BW'(rdEn);
        usbDataNext  = rdEn ? mem[rdPtr] : usbData;
        usbWriteNext = rdEn;
        usbEndNext   = rdEn & (wordCnt == LAST);
    end
endmodule

// File: tb/tb_usb_stream_buffer.sv
// tb_usb_stream_buffer: directed checks of usb_stream_buffer at default DEPTH=1024, BURST=256
module tb_usb_stream_buffer;
    logic        clock = 1'b0;
    logic        nReset = 1'b1;
    logic        runFlag = 1'b0;
    logic        fx3Ready = 1'b0;
    logic [15:0] adcData = '0;
    logic [15:0] usbData;
    logic        usbWrite, usbEndOfBurst, overflow;
    logic [10:0] fillLevel;

    int total = 0;
    int bad = 0;
    int sampIdx = 0;
    int expIdx = 1;
    int wib = 0;
    int runWords = 0;

    usb_stream_buffer dut (
        .clock(clock),
        .nReset(nReset),
        .runFlag(runFlag),
        .adcData(adcData),
        .fx3Ready(fx3Ready),
        .usbData(usbData),
        .usbWrite(usbWrite),
        .usbEndOfBurst(usbEndOfBurst),
        .overflow(overflow),
        .fillLevel(fillLevel)
    );

    always #5 clock = ~clock;

    // Value of the k-th stored word of a run (k counts from 1).
    function automatic logic [15:0] expVal(int k);
`ifdef TEST_PATTERN_EN
        return 16'(k - 1);
`else
        return 16'(k * 64);
`endif
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs 1 time unit after the edge, check any delivered word, advance the ramp.
    task automatic tick();
        @(posedge clock);
        #1;
        if (usbWrite) begin
            chk("word", usbData, expVal(expIdx));
            chk("eob", usbEndOfBurst, wib == 255);
            expIdx++;
            runWords++;
            wib = (wib == 255) ? 0 : wib + 1;
        end else
            chk("eobIdle", usbEndOfBurst, 0);
        if (runFlag) begin
            sampIdx++;
            adcData = 16'(sampIdx * 64);
        end
    endtask

    task automatic startRun(logic rdy);
        runFlag = 1'b0;
        fx3Ready = rdy;
        tick();
        runFlag = 1'b1;
        adcData = '0;
        sampIdx = 0;
        expIdx = 1;
        wib = 0;
        runWords = 0;
        tick();
    endtask

    initial begin
        int n;
        #3 nReset = 1'b0;
        #1;
        chk("rstData", usbData, 0);
        chk("rstWrite", usbWrite, 0);
        chk("rstEob", usbEndOfBurst, 0);
        chk("rstOvf", overflow, 0);
        chk("rstFill", fillLevel, 0);
        tick();
        tick();
        nReset = 1'b1;

        // first burst and the transition into the second
        startRun(1'b1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!usbWrite && n < 600);
        chk("firstWordCycle", n, 258);
        chk("firstFill", fillLevel, 257);
        repeat (255) tick();
        chk("lastEob", usbEndOfBurst, 1);
        chk("lastWord", usbData, expVal(256));
        tick();
        chk("gapWrite", usbWrite, 0);
        tick();
        chk("idleWrite", usbWrite, 0);
        tick();
        chk("burst2Write", usbWrite, 1);
        chk("burst2First", usbData, expVal(257));

        // stalls inside a burst
        fx3Ready = 1'b0;
        tick();
        chk("stall1Write", usbWrite, 0);
        chk("stall1Hold", usbData, expVal(257));
        fx3Ready = 1'b1;
        tick();
        chk("go1Write", usbWrite, 1);
        fx3Ready = 1'b0;
        tick();
        chk("stall2Write", usbWrite, 0);
        chk("stall2Hold", usbData, expVal(258));
        fx3Ready = 1'b1;
        tick();
        chk("go2Write", usbWrite, 1);
        repeat (300) tick();

        // saturation and overflow, then drain
        startRun(1'b0);
        chk("riseFill", fillLevel, 0);
        repeat (1024) tick();
        chk("fullFill", fillLevel, 1024);
        chk("fullNoOvf", overflow, 0);
        repeat (6) tick();
        chk("satFill", fillLevel, 1024);
        chk("satOvf", overflow, 1);
        runFlag = 1'b0;
        fx3Ready = 1'b1;
        repeat (1200) tick();
        chk("drainWords", runWords, 1024);
        chk("drainFill", fillLevel, 0);
        chk("ovfSticky", overflow, 1);

        // stop with a partial remainder
        startRun(1'b0);
        chk("riseOvfClr", overflow, 0);
        chk("riseFill2", fillLevel, 0);
        repeat (300) tick();
        chk("fill300", fillLevel, 300);
        runFlag = 1'b0;
        fx3Ready = 1'b1;
        repeat (600) tick();
        chk("stopWords", runWords, 256);
        chk("remainFill", fillLevel, 44);
        chk("remainIdle", usbWrite, 0);

        // asynchronous reset in the middle of a burst
        startRun(1'b1);
        n = 0;
        while (runWords < 100 && n < 1000) begin
            tick();
            n++;
        end
        chk("reach100", runWords, 100);
        #2 nReset = 1'b0;
        #1;
        chk("midRstData", usbData, 0);
        chk("midRstWrite", usbWrite, 0);
        chk("midRstEob", usbEndOfBurst, 0);
        chk("midRstFill", fillLevel, 0);
        chk("midRstOvf", overflow, 0);
        runFlag = 1'b0;
        tick();
        tick();
        nReset = 1'b1;
        repeat (10) tick();
        chk("postRstFill", fillLevel, 0);
        chk("postRstWrite", usbWrite, 0);
        chk("postRstWords", runWords, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
